// File: rtl/core_pkg.sv
// core_pkg: shared types and defaults for the signal-processing core control.
//   core_op_t   - command opcode (bits [1:0] of the command word)
//   seq_state_t - frame sequencer states
//   DEF_*       - default frame geometry and engine timeout
package core_pkg;

  localparam int DEF_FRAME_LEN   = 128;
  localparam int DEF_DATA_W      = 16;
  localparam int DEF_TIMEOUT_CYC = 4096;

  typedef enum logic [1:0] {
    OP_FFT = 2'b00,
    OP_FIR = 2'b01
  } core_op_t;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_RECV    = 3'd1,
    ST_START   = 3'd2,
    ST_COMPUTE = 3'd3,
    ST_FETCH   = 3'd4,
    ST_LOAD    = 3'd5,
    ST_XMIT    = 3'd6
  } seq_state_t;

endpackage

// File: rtl/core_sequencer_if.sv
// core_sequencer_if: receive, frame-buffer, engine, transmit and status signals
// of the frame sequencer.
//   master - the sequencer side (drives buffer, launches, tx, status)
//   slave  - the surrounding core (receiver, RAM, engines, transmitter)
interface core_sequencer_if #(
  parameter int DATA_W = 16,
  parameter int AW     = 7
);
  logic [DATA_W-1:0] rx_data;
  logic              rx_valid;
  logic              buf_we;
  logic [AW-1:0]     buf_addr;
  logic [DATA_W-1:0] buf_wdata;
  logic [DATA_W-1:0] buf_rdata;
  logic              fft_start;
  logic              fir_start;
  logic              eng_done;
  logic [DATA_W-1:0] tx_data;
  logic              tx_valid;
  logic              tx_done;
  logic              core_busy;
  logic              err_cmd;
  logic              err_timeout;
  logic              rx_drop;

  modport master (
    input  rx_data, rx_valid, buf_rdata, eng_done, tx_done,
    output buf_we, buf_addr, buf_wdata, fft_start, fir_start,
           tx_data, tx_valid, core_busy, err_cmd, err_timeout, rx_drop
  );

  modport slave (
    output rx_data, rx_valid, buf_rdata, eng_done, tx_done,
    input  buf_we, buf_addr, buf_wdata, fft_start, fir_start,
           tx_data, tx_valid, core_busy, err_cmd, err_timeout, rx_drop
  );
endinterface

// File: rtl/seq_timeout_ctr.sv
// seq_timeout_ctr: cycle counter with clear, enable and terminal-count flag.
//   clk, rstb - clock, async active-low reset
//   i_clr     - return count to 0 (wins over i_en)
//   i_en      - count one cycle; holds at terminal count
//   o_tc      - count has reached MAX_CYC-1
module seq_timeout_ctr #(
  parameter int MAX_CYC = 4096
) (
  input  logic clk,
  input  logic rstb,
  input  logic i_clr,
  input  logic i_en,
  output logic o_tc
);
  localparam int W = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;

  logic [W-1:0] r_cnt;

  assign o_tc = (r_cnt == W'(MAX_CYC - 1));

  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb)               r_cnt <= '0;
    else if (i_clr)          r_cnt <= '0;
    else if (i_en && !o_tc)  r_cnt <= r_cnt + W'(1);
  end
endmodule

// File: rtl/core_sequencer.sv
// core_sequencer: frame-level controller. Takes a command word and a frame of
// samples from rx, writes them to the shared buffer, launches FFT or FIR,
// waits for eng_done (engine rewrites the buffer in place) and streams the
// frame out on tx. All outputs are registered.
//   clk, rstb - clock, async active-low reset
//   bus       - core_sequencer_if.master (rx, buffer, engine, tx, status)
module core_sequencer
  import core_pkg::*;
#(
  parameter int FRAME_LEN   = DEF_FRAME_LEN,
  parameter int DATA_W      = DEF_DATA_W,
  parameter int TIMEOUT_CYC = DEF_TIMEOUT_CYC,
  parameter int AW          = $clog2(FRAME_LEN)
) (
  input logic clk,
  input logic rstb,
  core_sequencer_if.master bus
);
  localparam logic [2:0] S_IDLE    = ST_IDLE;
  localparam logic [2:0] S_RECV    = ST_RECV;
  localparam logic [2:0] S_START   = ST_START;
  localparam logic [2:0] S_COMPUTE = ST_COMPUTE;
  localparam logic [2:0] S_FETCH   = ST_FETCH;
  localparam logic [2:0] S_LOAD    = ST_LOAD;
  localparam logic [2:0] S_XMIT    = ST_XMIT;

  logic [2:0]        r_state;
  logic [AW-1:0]     r_cnt;
  logic              r_fir;
  logic              r_buf_we;
  logic [AW-1:0]     r_addr;
  logic [DATA_W-1:0] r_wdata;
  logic              r_fft_start;
  logic              r_fir_start;
  logic [DATA_W-1:0] r_tx_data;
  logic              r_tx_valid;
  logic              r_busy;
  logic              r_err_cmd;
  logic              r_err_to;
  logic              r_rx_drop;

  logic w_last;
  logic w_tc;
  logic w_drop_st;

  assign w_last    = (r_cnt == AW'(FRAME_LEN - 1));
  assign w_drop_st = (r_state != S_IDLE) && (r_state != S_RECV);

  seq_timeout_ctr #(.MAX_CYC(TIMEOUT_CYC)) u_tmo (
    .clk   (clk),
    .rstb  (rstb),
    .i_clr (r_state == S_START),
    .i_en  (r_state == S_COMPUTE),
    .o_tc  (w_tc)
  );

  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      r_state     <= S_IDLE;
      r_cnt       <= '0;
      r_fir       <= 1'b0;
      r_buf_we    <= 1'b0;
      r_addr      <= '0;
      r_wdata     <= '0;
      r_fft_start <= 1'b0;
      r_fir_start <= 1'b0;
      r_tx_data   <= '0;
      r_tx_valid  <= 1'b0;
      r_busy      <= 1'b0;
      r_err_cmd   <= 1'b0;
      r_err_to    <= 1'b0;
      r_rx_drop   <= 1'b0;
    end else begin
      r_buf_we    <= 1'b0;
      r_fft_start <= 1'b0;
      r_fir_start <= 1'b0;
      r_err_cmd   <= 1'b0;
      r_err_to    <= 1'b0;
      r_rx_drop   <= bus.rx_valid && w_drop_st;

      case (r_state)
        S_IDLE: begin
          if (bus.rx_valid) begin
            // opcodes 1x are invalid; only bit 1 separates them
            if (!bus.rx_data[1]) begin
              r_fir   <= (bus.rx_data[1:0] == OP_FIR);
              r_cnt   <= '0;
              r_state <= S_RECV;
              r_busy  <= 1'b1;
            end else begin
              r_err_cmd <= 1'b1;
            end
          end
        end
        S_RECV: begin
          if (bus.rx_valid) begin
            r_buf_we <= 1'b1;
            r_addr   <= r_cnt;
            r_wdata  <= bus.rx_data;
            if (w_last) r_state <= S_START;
            else        r_cnt   <= r_cnt + AW'(1);
          end
        end
        S_START: begin
          r_fft_start <= !r_fir;
          r_fir_start <= r_fir;
          r_state     <= S_COMPUTE;
        end
        S_COMPUTE: begin
          // eng_done on the terminal cycle still completes the frame
          if (bus.eng_done) begin
            r_cnt   <= '0;
            r_addr  <= '0;
            r_state <= S_FETCH;
          end else if (w_tc) begin
            r_err_to <= 1'b1;
            r_busy   <= 1'b0;
            r_state  <= S_IDLE;
          end
        end
        // address was loaded on entry, so the RAM read is already in flight
        S_FETCH: r_state <= S_LOAD;
        S_LOAD: begin
          r_tx_data  <= bus.buf_rdata;
          r_tx_valid <= 1'b1;
          r_state    <= S_XMIT;
        end
        S_XMIT: begin
          if (bus.tx_done) begin
            r_tx_valid <= 1'b0;
            if (w_last) begin
              r_busy  <= 1'b0;
              r_state <= S_IDLE;
            end else begin
              r_cnt   <= r_cnt + AW'(1);
              r_addr  <= r_cnt + AW'(1);
              r_state <= S_FETCH;
            end
          end
        end
        default: begin
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign bus.buf_we      = r_buf_we;
  assign bus.buf_addr    = r_addr;
  assign bus.buf_wdata   = r_wdata;
  assign bus.fft_start   = r_fft_start;
  assign bus.fir_start   = r_fir_start;
  assign bus.tx_data     = r_tx_data;
  assign bus.tx_valid    = r_tx_valid;
  assign bus.core_busy   = r_busy;
  assign bus.err_cmd     = r_err_cmd;
  assign bus.err_timeout = r_err_to;
  assign bus.rx_drop     = r_rx_drop;
endmodule

// File: tb/tb_core_sequencer.sv
module tb_core_sequencer;
  localparam int FL  = 128;
  localparam int DW  = 16;
  localparam int AW  = 7;
  localparam int TMO = 4096;

  localparam logic [4:0] EV_FFT  = 5'b10000;
  localparam logic [4:0] EV_FIR  = 5'b01000;
  localparam logic [4:0] EV_CMD  = 5'b00100;
  localparam logic [4:0] EV_TMO  = 5'b00010;
  localparam logic [4:0] EV_DROP = 5'b00001;

  logic clk = 1'b0;
  logic rstb = 1'b0;
  always #5 clk = ~clk;

  core_sequencer_if #(.DATA_W(DW), .AW(AW)) bus ();

  core_sequencer #(.FRAME_LEN(FL), .DATA_W(DW), .TIMEOUT_CYC(TMO), .AW(AW)) dut (
    .clk  (clk),
    .rstb (rstb),
    .bus  (bus)
  );

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  logic [AW+DW-1:0] wr_q[$];
  logic [DW-1:0]    tx_q[$];
  logic [4:0]       ev_q[$];

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", name, got, exp);
    end
  endtask

  task automatic fail_now(input string name);
    checks++;
    errors++;
    $display("FAIL %s", name);
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // frame buffer RAM and engine overwrite
  logic [DW-1:0] mem [0:FL-1];
  logic          eng_fill = 1'b0;
  logic [DW-1:0] eng_base = 16'h8000;
  always @(posedge clk) begin
    if (eng_fill) begin
      for (int k = 0; k < FL; k++) mem[k] <= eng_base + DW'(k);
    end else if (bus.buf_we) begin
      mem[bus.buf_addr] <= bus.buf_wdata;
    end
    bus.buf_rdata <= mem[bus.buf_addr];
  end

  // engine model: done 50 cycles after a start pulse
  logic eng_en = 1'b1;
  int   done_cyc = 0;
  initial begin
    bus.eng_done = 1'b0;
    forever begin
      @(negedge clk);
      if ((bus.fft_start || bus.fir_start) && eng_en) begin
        repeat (49) @(negedge clk);
        eng_fill = 1'b1;
        @(negedge clk);
        eng_fill = 1'b0;
        bus.eng_done = 1'b1;
        done_cyc = cyc;
        @(negedge clk);
        bus.eng_done = 1'b0;
      end
    end
  end

  // transmitter: accepts each word, stalls 10 cycles on global word 5
  int txn = 0;
  initial begin
    bus.tx_done = 1'b0;
    forever begin
      @(negedge clk);
      if (bus.tx_valid) begin
        if (txn == 5) repeat (10) @(negedge clk);
        bus.tx_done = 1'b1;
        @(negedge clk);
        bus.tx_done = 1'b0;
        txn++;
      end
    end
  end

  // monitor / scoreboard
  logic          prev_v = 1'b0;
  logic [DW-1:0] prev_d = '0;
  int            low_cnt = 0;
  int            words_frame = 0;
  int            start_cyc = 0;
  always @(negedge clk) begin
    logic [4:0] evc;
    if (bus.buf_we) begin
      if (wr_q.size() == 0) fail_now("unexpected_buf_write");
      else chk("buf_write", {bus.buf_addr, bus.buf_wdata}, wr_q.pop_front());
    end
    evc = {bus.fft_start, bus.fir_start, bus.err_cmd, bus.err_timeout, bus.rx_drop};
    if (evc != 5'b0) begin
      if (ev_q.size() == 0) fail_now("unexpected_pulse");
      else chk("pulse", evc, ev_q.pop_front());
    end
    if (bus.fft_start || bus.fir_start) start_cyc = cyc;
    if (bus.err_timeout) chk("timeout_latency", cyc - start_cyc, TMO);
    if (bus.tx_valid && !prev_v) begin
      if (tx_q.size() == 0) fail_now("unexpected_tx_word");
      else chk("tx_word", bus.tx_data, tx_q.pop_front());
      if (words_frame == 0) chk("done_to_tx_latency", cyc - done_cyc, 3);
      else chk("tx_gap", low_cnt, 2);
      words_frame++;
      low_cnt = 0;
    end else if (bus.tx_valid && prev_v) begin
      chk("tx_hold", bus.tx_data, prev_d);
    end
    if (!bus.tx_valid) low_cnt++;
    if (!bus.core_busy) words_frame = 0;
    prev_v = bus.tx_valid;
    prev_d = bus.tx_data;
  end

  // one rx word, called and returning at a negedge
  task automatic rx_word(input logic [DW-1:0] d);
    bus.rx_data  = d;
    bus.rx_valid = 1'b1;
    @(negedge clk);
    bus.rx_valid = 1'b0;
  endtask

  task automatic wait_idle(input int max_cyc);
    int i;
    for (i = 0; i < max_cyc && bus.core_busy; i++) @(negedge clk);
    if (bus.core_busy) fail_now("wait_idle_expired");
  endtask

  task automatic run_frame(input logic [DW-1:0] cmd, input logic [DW-1:0] dbase,
                           input logic [4:0] sev, input bit do_tx,
                           input logic [DW-1:0] txbase, input bit drop_cmp, input bit drop_tx);
    int i;
    rx_word(cmd);
    chk("busy_after_cmd", bus.core_busy, 1'b1);
    ev_q.push_back(sev);
    for (int k = 0; k < FL; k++) begin
      wr_q.push_back({AW'(k), dbase + DW'(k)});
      rx_word(dbase + DW'(k));
    end
    if (do_tx) for (int k = 0; k < FL; k++) tx_q.push_back(txbase + DW'(k));
    else ev_q.push_back(EV_TMO);
    if (drop_cmp) begin
      repeat (3) @(negedge clk);
      ev_q.push_back(EV_DROP);
      rx_word(16'hDEAD);
    end
    if (drop_tx) begin
      for (i = 0; i < 3000 && !(bus.tx_valid && words_frame >= 3); i++) @(negedge clk);
      if (!bus.tx_valid) fail_now("wait_xmit_expired");
      else begin
        ev_q.push_back(EV_DROP);
        rx_word(16'hBEEF);
      end
    end
    wait_idle(6000);
    repeat (3) @(negedge clk);
    chk("busy_idle", bus.core_busy, 1'b0);
    chk("wr_q_drained", wr_q.size(), 0);
    chk("tx_q_drained", tx_q.size(), 0);
    chk("ev_q_drained", ev_q.size(), 0);
  endtask

  function automatic logic [46:0] all_outs();
    return {bus.buf_we, bus.buf_addr, bus.buf_wdata, bus.fft_start, bus.fir_start,
            bus.tx_data, bus.tx_valid, bus.core_busy, bus.err_cmd, bus.err_timeout, bus.rx_drop};
  endfunction

  initial begin
    #500000;
    $display("FAIL watchdog_expired");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.rx_data  = '0;
    bus.rx_valid = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset_outputs", all_outs(), '0);
    rstb = 1'b1;
    repeat (2) @(negedge clk);

    // FFT frame, drops in COMPUTE and XMIT, stall on word 5
    eng_base = 16'h8000;
    run_frame(16'h0000, 16'h0000, EV_FFT, 1'b1, 16'h8000, 1'b1, 1'b1);

    // invalid opcode, then FIR frame
    ev_q.push_back(EV_CMD);
    rx_word(16'h0003);
    @(negedge clk);
    chk("busy_after_bad_cmd", bus.core_busy, 1'b0);
    eng_base = 16'h9000;
    run_frame(16'h0001, 16'h4000, EV_FIR, 1'b1, 16'h9000, 1'b0, 1'b0);

    // FIR frame with no engine completion
    eng_en = 1'b0;
    run_frame(16'hFFF1, 16'h2000, EV_FIR, 1'b0, 16'h0, 1'b0, 1'b0);
    eng_en = 1'b1;

    // reset after 60 samples
    rx_word(16'h0000);
    for (int k = 0; k < 60; k++) begin
      wr_q.push_back({AW'(k), 16'h3000 + DW'(k)});
      rx_word(16'h3000 + DW'(k));
    end
    #2 rstb = 1'b0;
    #1 chk("async_reset_outputs", all_outs(), '0);
    chk("wr_q_before_reset", wr_q.size(), 0);
    repeat (2) @(negedge clk);
    chk("outputs_held_in_reset", all_outs(), '0);
    rstb = 1'b1;
    @(negedge clk);
    eng_base = 16'h8000;
    run_frame(16'h0000, 16'h0100, EV_FFT, 1'b1, 16'h8000, 1'b0, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
